// File: rtl/opa_ctl_fsm_if.sv
// Memory-side handshakes of the multi-cycle control FSM.
// master = controller, slave = instruction/data memory.
interface opa_ctl_fsm_if;
  logic        io_imem_req_valid;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_inst;
  logic        io_dmem_req_valid;
  logic        io_dmem_req_rw;
  logic        io_dmem_resp_valid;

  modport master (
    output io_imem_req_valid,
    input  io_imem_resp_valid,
    input  io_imem_resp_inst,
    output io_dmem_req_valid,
    output io_dmem_req_rw,
    input  io_dmem_resp_valid
  );

  modport slave (
    input  io_imem_req_valid,
    output io_imem_resp_valid,
    output io_imem_resp_inst,
    input  io_dmem_req_valid,
    input  io_dmem_req_rw,
    output io_dmem_resp_valid
  );
endinterface

// File: rtl/opa_ctl_fsm.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute,
// memory and writeback with one instruction in flight.
module opa_ctl_fsm #(
  parameter bit RESET_TRAP_CLEAR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  opa_ctl_fsm_if.master    io_mem,
  input  logic             io_br_taken,
  output logic             io_ir_en,
  output logic             io_pc_en,
  output logic [1:0]       io_pc_sel,
  output logic [1:0]       io_opa_sel,
  output logic [1:0]       io_opb_sel,
  output logic [3:0]       io_alu_fun,
  output logic [1:0]       io_wb_sel,
  output logic             io_rf_wen,
  output logic             io_illegal
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic        r_br;

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_rd0;
  logic       w_op;
  logic       w_opi;
  logic       w_lui;
  logic       w_ld;
  logic       w_st;
  logic       w_bra;
  logic       w_jal;
  logic       w_jalr;
  logic       w_csri;
  logic       w_legal;

  logic [1:0] w_opa;
  logic [1:0] w_opb;
  logic [3:0] w_alu;
  logic [1:0] w_wb;
  logic [1:0] w_pcs;

  assign w_opc  = r_ir[6:0];
  assign w_f3   = r_ir[14:12];
  assign w_f7b5 = r_ir[30];
  assign w_rd0  = (r_ir[11:7] == 5'd0);
  assign w_op   = (w_opc == 7'b0110011);
  assign w_opi  = (w_opc == 7'b0010011);
  assign w_lui  = (w_opc == 7'b0110111);
  assign w_ld   = (w_opc == 7'b0000011);
  assign w_st   = (w_opc == 7'b0100011);
  assign w_bra  = (w_opc == 7'b1100011);
  assign w_jal  = (w_opc == 7'b1101111);
  assign w_jalr = (w_opc == 7'b1100111);
  assign w_csri = (w_opc == 7'b1110011) & w_f3[2];

  // Only word loads/stores exist in this datapath.
  assign w_legal = w_op | w_opi | w_lui | w_bra
                 | w_jal | w_jalr | w_csri
                 | (w_ld & (w_f3 == 3'b010))
                 | (w_st & (w_f3 == 3'b010));

  // Datapath settings derived from the latched IR.
  always_comb begin
    w_opa = 2'd0;
    w_opb = 2'd1;
    w_alu = 4'b0000;
    w_wb  = 2'd0;
    w_pcs = 2'd0;
    if (w_lui)       w_opa = 2'd2;
    else if (w_csri) w_opa = 2'd1;
    if (w_op | w_bra) w_opb = 2'd0;
    else if (w_st)    w_opb = 2'd2;
    if (w_op)
      w_alu = {w_f7b5, w_f3};
    else if (w_opi)
      w_alu = {w_f7b5 & (w_f3 == 3'b101), w_f3};
    else if (w_bra)
      w_alu = 4'b1000;
    else if (w_lui | w_csri)
      w_alu = 4'b1111;
    if (w_ld)               w_wb = 2'd1;
    else if (w_jal | w_jalr) w_wb = 2'd2;
    if (w_jal | (w_bra & r_br)) w_pcs = 2'd1;
    else if (w_jalr)            w_pcs = 2'd2;
  end

  // State, instruction register and branch flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (RESET_TRAP_CLEAR || (r_state != S_TRAP))
        r_state <= S_FETCH;
      r_ir <= '0;
      r_br <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FETCH) && io_mem.io_imem_resp_valid)
        r_ir <= io_mem.io_imem_resp_inst;
      if (r_state == S_EXEC)
        r_br <= io_br_taken;
    end
  end

  // Next state and control outputs; reset forces all low.
  always_comb begin
    w_next = r_state;
    io_mem.io_imem_req_valid = 1'b0;
    io_mem.io_dmem_req_valid = 1'b0;
    io_mem.io_dmem_req_rw    = 1'b0;
    io_ir_en   = 1'b0;
    io_pc_en   = 1'b0;
    io_pc_sel  = 2'd0;
    io_opa_sel = 2'd0;
    io_opb_sel = 2'd0;
    io_alu_fun = 4'd0;
    io_wb_sel  = 2'd0;
    io_rf_wen  = 1'b0;
    io_illegal = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        io_mem.io_imem_req_valid = 1'b1;
        if (io_mem.io_imem_resp_valid) begin
          io_ir_en = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = w_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        io_opa_sel = w_opa;
        io_opb_sel = w_opb;
        io_alu_fun = w_alu;
        w_next = (w_ld | w_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        io_opa_sel = w_opa;
        io_opb_sel = w_opb;
        io_alu_fun = w_alu;
        io_mem.io_dmem_req_valid = 1'b1;
        io_mem.io_dmem_req_rw    = w_st;
        if (io_mem.io_dmem_resp_valid)
          w_next = S_WB;
      end
      S_WB: begin
        io_opa_sel = w_opa;
        io_opb_sel = w_opb;
        io_alu_fun = w_alu;
        io_wb_sel  = w_wb;
        io_pc_sel  = w_pcs;
        io_pc_en   = 1'b1;
        io_rf_wen  = ~(w_st | w_bra | w_rd0);
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        io_illegal = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
    if (reset) begin
      io_mem.io_imem_req_valid = 1'b0;
      io_mem.io_dmem_req_valid = 1'b0;
      io_mem.io_dmem_req_rw    = 1'b0;
      io_ir_en   = 1'b0;
      io_pc_en   = 1'b0;
      io_pc_sel  = 2'd0;
      io_opa_sel = 2'd0;
      io_opb_sel = 2'd0;
      io_alu_fun = 4'd0;
      io_wb_sel  = 2'd0;
      io_rf_wen  = 1'b0;
      io_illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_opa_ctl_fsm.sv
// Testbench for opa_ctl_fsm: random instruction stream
// checked every cycle against a per-phase output model.
module tb_opa_ctl_fsm;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_rw;
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic [1:0] opa;
    logic [1:0] opb;
    logic [3:0] alu;
    logic [1:0] wb;
    logic       rf_wen;
    logic       illegal;
  } out_t;

  localparam int PH_FIDLE = 0;
  localparam int PH_FRESP = 1;
  localparam int PH_DEC   = 2;
  localparam int PH_EXEC  = 3;
  localparam int PH_MEM   = 4;
  localparam int PH_WB    = 5;
  localparam int PH_TRAP  = 6;
  localparam int PH_RST   = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_br_taken;
  logic       io_ir_en;
  logic       io_pc_en;
  logic [1:0] io_pc_sel;
  logic [1:0] io_opa_sel;
  logic [1:0] io_opb_sel;
  logic [3:0] io_alu_fun;
  logic [1:0] io_wb_sel;
  logic       io_rf_wen;
  logic       io_illegal;

  opa_ctl_fsm_if mif();

  opa_ctl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .io_mem     (mif.master),
    .io_br_taken(io_br_taken),
    .io_ir_en   (io_ir_en),
    .io_pc_en   (io_pc_en),
    .io_pc_sel  (io_pc_sel),
    .io_opa_sel (io_opa_sel),
    .io_opb_sel (io_opb_sel),
    .io_alu_fun (io_alu_fun),
    .io_wb_sel  (io_wb_sel),
    .io_rf_wen  (io_rf_wen),
    .io_illegal (io_illegal)
  );

  always #5 clk = ~clk;

  out_t act;
  out_t exp_o;
  bit   chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cur_ph = 0;
  out_t cap_ex, cap_wb, cap_tr, cap_f;
  int   dcnt;

  assign act = {mif.io_imem_req_valid, mif.io_dmem_req_valid,
                mif.io_dmem_req_rw, io_ir_en, io_pc_en,
                io_pc_sel, io_opa_sel, io_opb_sel, io_alu_fun,
                io_wb_sel, io_rf_wen, io_illegal};

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (act === exp_o) n_pass++;
      else $display("FAIL cycle t=%0t ph=%0d act=%h exp=%h",
                    $time, cur_ph, act, exp_o);
    end
  end

  function automatic bit legal(input logic [31:0] in);
    logic [6:0] o;
    logic [2:0] f3;
    o  = in[6:0];
    f3 = in[14:12];
    case (o)
      7'h33, 7'h13, 7'h37, 7'h63, 7'h6f, 7'h67: return 1'b1;
      7'h03, 7'h23: return f3 == 3'b010;
      7'h73: return f3[2];
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs for a given phase of an instruction.
  function automatic out_t model(input logic [31:0] in,
                                 input int ph, input bit br);
    out_t o;
    logic [6:0] opc;
    logic [2:0] f3;
    bit ld, st, op, opi, lui, bra, jal, jalr, csri;
    o    = '0;
    opc  = in[6:0];
    f3   = in[14:12];
    ld   = opc == 7'h03;
    st   = opc == 7'h23;
    op   = opc == 7'h33;
    opi  = opc == 7'h13;
    lui  = opc == 7'h37;
    bra  = opc == 7'h63;
    jal  = opc == 7'h6f;
    jalr = opc == 7'h67;
    csri = (opc == 7'h73) && f3[2];
    if (ph == PH_FIDLE) o.imem_req = 1'b1;
    if (ph == PH_FRESP) begin
      o.imem_req = 1'b1;
      o.ir_en = 1'b1;
    end
    if (ph == PH_TRAP) o.illegal = 1'b1;
    if (ph == PH_EXEC || ph == PH_MEM || ph == PH_WB) begin
      o.opa = lui ? 2'd2 : (csri ? 2'd1 : 2'd0);
      o.opb = (op || bra) ? 2'd0 : (st ? 2'd2 : 2'd1);
      if (op) o.alu = {in[30], f3};
      else if (opi) o.alu = {in[30] && f3 == 3'd5, f3};
      else if (bra) o.alu = 4'd8;
      else if (lui || csri) o.alu = 4'd15;
      else o.alu = 4'd0;
    end
    if (ph == PH_MEM) begin
      o.dmem_req = 1'b1;
      o.dmem_rw = st;
    end
    if (ph == PH_WB) begin
      o.pc_en = 1'b1;
      o.rf_wen = !(st || bra) && in[11:7] != 5'd0;
      o.wb = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
      o.pc_sel = (jal || (bra && br)) ? 2'd1
               : (jalr ? 2'd2 : 2'd0);
    end
    return o;
  endfunction

  task automatic lit(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s act=%h exp=%h", nm, a, e);
  endtask

  task automatic noise();
    mif.io_imem_resp_valid = 1'($urandom);
    mif.io_imem_resp_inst  = $urandom;
    mif.io_dmem_resp_valid = 1'($urandom);
    io_br_taken            = 1'($urandom);
  endtask

  task automatic step(input logic [31:0] in, input int ph,
                      input bit br);
    cur_ph = ph;
    exp_o  = model(in, ph, br);
    @(negedge clk);
    #1;
    if (ph == PH_EXEC) cap_ex = act;
    if (ph == PH_WB)   cap_wb = act;
    if (ph == PH_TRAP) cap_tr = act;
    if (ph == PH_FIDLE || ph == PH_FRESP) cap_f = act;
    if (ph == PH_MEM && act.dmem_req) dcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      noise();
      step('0, PH_RST, 1'b0);
    end
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] in, input int ilat,
                           input int dlat, input bit br,
                           input bit abort);
    bit memop;
    memop = legal(in) && (in[6:0] == 7'h03 || in[6:0] == 7'h23);
    dcnt = 0;
    for (int i = 0; i < ilat; i++) begin
      noise();
      mif.io_imem_resp_valid = 1'b0;
      step(in, PH_FIDLE, br);
    end
    noise();
    mif.io_imem_resp_valid = 1'b1;
    mif.io_imem_resp_inst  = in;
    step(in, PH_FRESP, br);
    noise();
    step(in, PH_DEC, br);
    if (!legal(in)) begin
      for (int i = 0; i < 20; i++) begin
        noise();
        step(in, PH_TRAP, br);
      end
      return;
    end
    noise();
    io_br_taken = br;
    step(in, PH_EXEC, br);
    if (memop) begin
      for (int k = 0; k < dlat; k++) begin
        noise();
        if (abort && k == 1) begin
          do_reset();
          return;
        end
        mif.io_dmem_resp_valid = (k == dlat - 1);
        step(in, PH_MEM, br);
      end
    end
    noise();
    step(in, PH_WB, br);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [31:0] in;
    int t;
    r = $urandom;
    t = $urandom_range(0, 9);
    case (t)
      0: in = {r[31:7], 7'h33};
      1: in = {r[31:7], 7'h13};
      2: in = {r[31:7], 7'h37};
      3: in = {r[31:15], 3'b010, r[11:7], 7'h03};
      4: in = {r[31:15], 3'b010, r[11:7], 7'h23};
      5: in = {r[31:7], 7'h63};
      6: in = {r[31:7], 7'h6f};
      7: in = {r[31:7], 7'h67};
      8: in = {r[31:15], 1'b1, r[13:7], 7'h73};
      default: in = r;
    endcase
    if ($urandom_range(0, 3) == 0) in[11:7] = 5'd0;
    return in;
  endfunction

  initial begin
    logic [31:0] in;
    reset = 1'b1;
    noise();
    exp_o = '0;
    cur_ph = PH_RST;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    lit("reset_outputs_zero", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    run_instr(32'h00500093, 0, 1, 1'b0, 1'b0);
    lit("addi_ex_opa", 32'(cap_ex.opa), 32'd0);
    lit("addi_ex_opb", 32'(cap_ex.opb), 32'd1);
    lit("addi_ex_alu", 32'(cap_ex.alu), 32'd0);
    lit("addi_wb", 32'({cap_wb.rf_wen, cap_wb.wb,
                        cap_wb.pc_en, cap_wb.pc_sel}),
        32'b1_00_1_00);

    run_instr(32'h12345137, 1, 1, 1'b0, 1'b0);
    lit("lui_ex_opa", 32'(cap_ex.opa), 32'd2);
    lit("lui_wb_alu", 32'(cap_wb.alu), 32'hf);
    lit("lui_wb_wen", 32'(cap_wb.rf_wen), 32'd1);

    run_instr(32'h3002D1F3, 0, 1, 1'b0, 1'b0);
    lit("csri_ex", 32'({cap_ex.opa, cap_ex.opb, cap_ex.alu}),
        32'b01_01_1111);
    lit("csri_wen", 32'(cap_wb.rf_wen), 32'd1);

    run_instr(32'h0000A203, 0, 3, 1'b0, 1'b0);
    lit("lw_mem_cycles", 32'(dcnt), 32'd3);
    lit("lw_wb", 32'({cap_wb.wb, cap_wb.rf_wen}), 32'b01_1);

    run_instr(32'h0000A203, 0, 3, 1'b0, 1'b1);
    run_instr(32'h00500093, 0, 1, 1'b0, 1'b0);
    lit("abort_then_fetch", 32'({cap_f.imem_req, cap_f.rf_wen}),
        32'b1_0);

    run_instr(32'h00000463, 0, 1, 1'b1, 1'b0);
    lit("beq_taken_wb", 32'({cap_wb.pc_sel, cap_wb.pc_en,
                             cap_wb.rf_wen}), 32'b01_1_0);
    run_instr(32'h00000463, 0, 1, 1'b0, 1'b0);
    lit("beq_not_taken", 32'(cap_wb.pc_sel), 32'd0);

    run_instr(32'h00000000, 0, 1, 1'b0, 1'b0);
    lit("trap_illegal", 32'({cap_tr.illegal, cap_tr.imem_req}),
        32'b1_0);
    do_reset();
    run_instr(32'h00500093, 0, 1, 1'b0, 1'b0);
    lit("post_trap_fetch", 32'({cap_f.illegal, cap_f.imem_req}),
        32'b0_1);

    for (int n = 0; n < 80; n++) begin
      in = rand_inst();
      run_instr(in, $urandom_range(0, 2), $urandom_range(1, 3),
                1'($urandom), ($urandom_range(0, 7) == 0));
      if (!legal(in)) do_reset();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
